// File: rtl/xor_parity_bank.sv
// rtl/xor_parity_bank.sv - registered per-channel XOR parity with programmable inversion and block accumulator
module xor_parity_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int ACC_LEN  = 16,
    parameter int CNT_W    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*CHANNELS-1:0] a,
    input  logic [WIDTH*CHANNELS-1:0] b,
    input  logic                      in_valid,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic                      cfg_inv,
    input  logic                      acc_flush,
    output logic [CHANNELS-1:0]       z,
    output logic                      z_valid,
    output logic [CHANNELS-1:0]       acc_parity,
    output logic                      acc_done,
    output logic [CNT_W-1:0]          acc_len,
    output logic [CNT_W-1:0]          acc_count
);

    logic [CHANNELS-1:0] inv;
    logic [CHANNELS-1:0] acc;
    logic [CHANNELS-1:0] p;
    logic [CHANNELS-1:0] p_masked;
    logic                block_end;
    logic                terminal;

    always_comb begin
        p = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            p[i] = (^(a[i*WIDTH +: WIDTH] ^ b[i*WIDTH +: WIDTH])) ^ inv[i];
        end
    end

    // A flush with nothing folded and no sample this cycle would emit an empty block; suppress it.
    assign block_end = in_valid && (acc_count == CNT_W'(ACC_LEN - 1));
    assign terminal  = block_end || (acc_flush && ((acc_count != '0) || in_valid));
    assign p_masked  = in_valid ? p : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            z          <= '0;
            z_valid    <= 1'b0;
            inv        <= '0;
            acc        <= '0;
            acc_count  <= '0;
            acc_parity <= '0;
            acc_len    <= '0;
            acc_done   <= 1'b0;
        end else begin
            if (in_valid) begin
                z <= p;
            end
            z_valid <= in_valid;

            // Out-of-range channel indices match no loop iteration and are dropped.
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    inv[i] <= cfg_inv;
                end
            end

            if (terminal) begin
                acc_parity <= acc ^ p_masked;
                acc_len    <= acc_count + CNT_W'(in_valid);
                acc_done   <= 1'b1;
                acc        <= '0;
                acc_count  <= '0;
            end else begin
                acc_done <= 1'b0;
                if (in_valid) begin
                    acc       <= acc ^ p;
                    acc_count <= acc_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_parity_bank.sv
// tb/tb_xor_parity_bank.sv - directed self-checking bench for xor_parity_bank
module tb_xor_parity_bank;

    localparam int W   = 4;
    localparam int C   = 2;
    localparam int CHW = 1;
    localparam int AL  = 4;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [W*C-1:0] a;
    logic [W*C-1:0] b;
    logic           in_valid;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_ch2;
    logic           cfg_inv;
    logic           acc_flush;

    logic [C-1:0]   z, acc_parity;
    logic           z_valid, acc_done;
    logic [CW-1:0]  acc_len, acc_count;

    logic [C-1:0]   z2, acc_parity2;
    logic           z_valid2, acc_done2;
    logic [CW-1:0]  acc_len2, acc_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_parity_bank #(.WIDTH(W), .CHANNELS(C), .CH_W(CHW), .ACC_LEN(AL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inv(cfg_inv), .acc_flush(acc_flush),
        .z(z), .z_valid(z_valid), .acc_parity(acc_parity), .acc_done(acc_done),
        .acc_len(acc_len), .acc_count(acc_count)
    );

    // Wider index build: indices 2 and 3 address no channel.
    xor_parity_bank #(.WIDTH(W), .CHANNELS(C), .CH_W(2), .ACC_LEN(AL), .CNT_W(CW)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch2), .cfg_inv(cfg_inv), .acc_flush(acc_flush),
        .z(z2), .z_valid(z_valid2), .acc_parity(acc_parity2), .acc_done(acc_done2),
        .acc_len(acc_len2), .acc_count(acc_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input logic done, input logic [C-1:0] par,
                           input logic [CW-1:0] len, input logic [CW-1:0] cnt);
        chk({tag, ".acc_done"},   acc_done,   done);
        chk({tag, ".acc_parity"}, acc_parity, par);
        chk({tag, ".acc_len"},    acc_len,    len);
        chk({tag, ".acc_count"},  acc_count,  cnt);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [W*C-1:0] av, input logic [W*C-1:0] bv);
        a = av;
        b = bv;
        in_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; a = '0; b = '0; in_valid = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_ch2 = '0; cfg_inv = 1'b0; acc_flush = 1'b0;

        // Reset dominates sample, config write and flush
        for (int k = 0; k < 2; k++) begin
            a = W*C'($urandom); b = W*C'($urandom); in_valid = 1'b1;
            cfg_we = 1'b1; cfg_ch = CHW'(k); cfg_inv = 1'b1; acc_flush = 1'b1;
            tick();
            chk("rst.z", z, 2'b00);
            chk("rst.z_valid", z_valid, 1'b0);
            chk_acc("rst", 1'b0, 2'b00, 3'd0, 3'd0);
        end

        // First sample with a same-cycle write to inv[0]: old inv (0) applies
        reset = 1'b0; acc_flush = 1'b0;
        sample({4'b0111, 4'b0011}, 8'h00);
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_inv = 1'b1;
        tick();
        chk("s1.z", z, 2'b10);
        chk("s1.z_valid", z_valid, 1'b1);
        chk("s1.acc_count", acc_count, 3'd1);

        in_valid = 1'b0; cfg_we = 1'b0;
        tick();
        chk("hold.z", z, 2'b10);
        chk("hold.z_valid", z_valid, 1'b0);

        // Same sample now sees inv[0]=1
        sample({4'b0111, 4'b0011}, 8'h00);
        tick();
        chk("s2.z", z, 2'b11);
        chk("s2.acc_count", acc_count, 3'd2);

        // Flush alone: block of 2, acc = 10 ^ 11 = 01; clear inv[0] at the same time
        in_valid = 1'b0; acc_flush = 1'b1; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_inv = 1'b0;
        tick();
        chk_acc("flush1", 1'b1, 2'b01, 3'd2, 3'd0);

        // Flush with empty block and no sample: no-op
        cfg_we = 1'b0;
        tick();
        chk_acc("flush_empty", 1'b0, 2'b01, 3'd2, 3'd0);

        // Set inv[1], then sample zeros while clearing it: old inv[1]=1 used
        acc_flush = 1'b0; cfg_we = 1'b1; cfg_ch = 1'b1; cfg_inv = 1'b1;
        tick();
        sample(8'h00, 8'h00); cfg_inv = 1'b0;
        tick();
        chk("inv1.z", z, 2'b10);
        chk("inv1.acc_count", acc_count, 3'd1);

        // Flush with valid at cnt=1: acc 10 ^ p 01 -> 11, len 2
        cfg_we = 1'b0; acc_flush = 1'b1;
        sample({4'b0000, 4'b0001}, 8'h00);
        tick();
        chk("fv2.z", z, 2'b01);
        chk_acc("fv2", 1'b1, 2'b11, 3'd2, 3'd0);

        // Back-to-back: flush with valid at cnt=0 -> len 1
        sample({4'b0000, 4'b0001}, 8'h00);
        tick();
        chk_acc("fv1", 1'b1, 2'b01, 3'd1, 3'd0);

        acc_flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("idle.acc_done", acc_done, 1'b0);

        // Full block: ch0 parity 1,0,1,1; ch1 0
        sample({4'b0000, 4'b0001}, 8'h00);
        tick();
        chk("blk.c1", acc_count, 3'd1);
        sample({4'b1100, 4'b0000}, {4'b1100, 4'b0000});
        tick();
        chk("blk.c2", acc_count, 3'd2);
        sample({4'b0000, 4'b0111}, 8'h00);
        tick();
        chk("blk.c3", acc_count, 3'd3);
        chk("blk.c3.acc_done", acc_done, 1'b0);
        sample({4'b0000, 4'b1010}, {4'b0000, 4'b0010});
        tick();
        chk("blk.z", z, 2'b01);
        chk_acc("blk", 1'b1, 2'b01, 3'd4, 3'd0);

        // 5th sample opens a new block; previous results hold
        sample({4'b0001, 4'b0000}, 8'h00);
        tick();
        chk_acc("blk5", 1'b0, 2'b01, 3'd4, 3'd1);

        // Two more then reset mid-block; reset also wins over a write to inv[0]
        sample(8'h11, 8'h00);
        tick();
        tick();
        chk("pre_rst.acc_count", acc_count, 3'd3);
        reset = 1'b1; acc_flush = 1'b1; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_inv = 1'b1;
        tick();
        chk_acc("midrst", 1'b0, 2'b00, 3'd0, 3'd0);

        // Clean block after reset: ch0 1,1,1,0; ch1 0,0,0,1 -> 11
        reset = 1'b0; acc_flush = 1'b0; cfg_we = 1'b0;
        sample({4'b0000, 4'b0001}, 8'h00);
        tick();
        chk("post.z", z, 2'b01);
        chk("post.acc_done", acc_done, 1'b0);
        tick();
        tick();
        sample({4'b0100, 4'b0000}, 8'h00);
        tick();
        chk_acc("post", 1'b1, 2'b11, 3'd4, 3'd0);

        // Wide-index build: writes to channel 2 and 3 are dropped
        in_valid = 1'b0; cfg_we = 1'b1; cfg_inv = 1'b1; cfg_ch2 = 2'd2;
        tick();
        cfg_ch2 = 2'd3;
        tick();
        cfg_we = 1'b0;
        sample(8'h00, 8'h00);
        tick();
        chk("wide.oob.z", z2, 2'b00);
        in_valid = 1'b0; cfg_we = 1'b1; cfg_ch2 = 2'd1;
        tick();
        cfg_we = 1'b0;
        sample(8'h00, 8'h00);
        tick();
        chk("wide.ch1.z", z2, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
